// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot-time ROM loader.
package rom_loader_pkg;

    localparam int unsigned DEFAULT_ROM_SIZE = 4096;
    localparam int unsigned WIDTH            = 32;
    localparam int unsigned LEN_BYTES        = 4;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    // Fold one stream byte into the running XOR checksum.
    function automatic byte_t csum_step(input byte_t acc, input byte_t b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/rom_loader_byte_writer.sv
// ROM byte storage: one write port, full synchronous clear on reset.
module rom_byte_writer
    import rom_loader_pkg::*;
#(
    parameter int unsigned ROM_SIZE = DEFAULT_ROM_SIZE,
    parameter int unsigned AW       = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    data,
    output logic [7:0]    rom [0:ROM_SIZE-1]
);

    // Clear every byte on reset; otherwise write a single byte when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ROM_SIZE; i++) begin
                rom[i] <= '0;
            end
        end else if (we) begin
            rom[addr] <= data;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: parses a length/payload/check frame, fills the ROM and
// releases the core reset only after the checksum verifies.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned ROM_SIZE   = DEFAULT_ROM_SIZE,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [7:0]       rom [0:ROM_SIZE-1],
    output logic             cpu_rst,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] bytes_loaded
);

    localparam int unsigned AW = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1;

    loader_state_t    r_state;
    logic [WIDTH-1:0] r_len;
    logic [1:0]       r_lcnt;
    logic [WIDTH-1:0] r_idx;
    logic [7:0]       r_csum;
    logic [WIDTH-1:0] r_bytes;
    logic             r_in_ready;
    logic             r_cpu_rst;
    logic             r_done;
    logic             r_error;

    logic             w_fire;
    logic             w_we;
    logic [WIDTH-1:0] w_len_next;
    logic [WIDTH-1:0] w_idx_next;
    logic [AW-1:0]    w_addr;

    // Handshake, next-length shift value and ROM write strobe.
    always_comb begin
        w_fire     = in_valid && r_in_ready;
        w_we       = w_fire && (r_state == DATA);
        w_len_next = {r_len[WIDTH-9:0], in_data};
        w_idx_next = r_idx + 1'b1;
        w_addr     = r_idx[AW-1:0];
    end

    rom_byte_writer #(
        .ROM_SIZE (ROM_SIZE),
        .AW       (AW)
    ) u_writer (
        .clk  (clk),
        .rst  (rst),
        .we   (w_we),
        .addr (w_addr),
        .data (in_data),
        .rom  (rom)
    );

    // Frame FSM with length shifter, index, checksum and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= AUTO_START ? LEN : IDLE;
            r_len      <= '0;
            r_lcnt     <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_bytes    <= '0;
            r_in_ready <= AUTO_START;
            r_cpu_rst  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state    <= LEN;
                        r_len      <= '0;
                        r_lcnt     <= '0;
                        r_idx      <= '0;
                        r_csum     <= '0;
                        r_bytes    <= '0;
                        r_in_ready <= 1'b1;
                        r_cpu_rst  <= 1'b0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                LEN: begin
                    if (w_fire) begin
                        r_len  <= w_len_next;
                        r_lcnt <= r_lcnt + 1'b1;
                        if (r_lcnt == 2'(LEN_BYTES - 1)) begin
                            if (w_len_next > 32'(ROM_SIZE)) begin
                                r_state    <= ERROR;
                                r_in_ready <= 1'b0;
                                r_error    <= 1'b1;
                            end else if (w_len_next == '0) begin
                                r_state <= CHECK;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        r_idx   <= w_idx_next;
                        r_csum  <= csum_step(r_csum, in_data);
                        r_bytes <= r_bytes + 1'b1;
                        if (w_idx_next == r_len) begin
                            r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_fire) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_csum) begin
                            r_state   <= DONE;
                            r_cpu_rst <= 1'b1;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign cpu_rst      = r_cpu_rst;
    assign done         = r_done;
    assign error        = r_error;
    assign bytes_loaded = r_bytes;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table vectors, corner sequences and
// randomized frames against a frame-level reference model.
module tb_rom_loader;

    localparam int unsigned RS = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [7:0]  rom [0:RS-1];
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [31:0] bytes_loaded;

    rom_loader #(
        .ROM_SIZE   (RS),
        .AUTO_START (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rom          (rom),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m_rom [RS];
    logic [7:0] pay_q [$];

    typedef struct {
        logic [31:0] n;
        logic [7:0]  pay [8];
        logic [7:0]  chk;
        bit          exp_done;
        bit          exp_err;
        logic [31:0] exp_bytes;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_rom(input string name);
        int bad = 0;
        for (int i = 0; i < int'(RS); i++) begin
            if (rom[i] !== m_rom[i]) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(RS); i++) m_rom[i] = 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after an idle gap; wait (bounded) for it to be taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
    endtask

    // Reference: outcome of a whole frame from the framing rules.
    task automatic model_frame(input logic [31:0] n, input logic [7:0] chk,
                               output bit md, output bit me, output logic [31:0] mb);
        logic [7:0] x = 8'h00;
        if (n > RS) begin
            md = 1'b0; me = 1'b1; mb = 32'd0;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                m_rom[i] = pay_q[i];
                x ^= pay_q[i];
            end
            md = (chk == x);
            me = !md;
            mb = n;
        end
    endtask

    task automatic run_frame(input logic [31:0] n, input logic [7:0] chk, input int max_gap,
                             output bit md, output bit me, output logic [31:0] mb);
        logic [31:0] nn = n;
        pulse_start();
        check("in_ready_len", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            send_byte(nn[31:24], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            nn = nn << 8;
        end
        if (n <= RS) begin
            for (int i = 0; i < int'(n); i++) begin
                send_byte(pay_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
                check("bytes_step", bytes_loaded, 32'(i + 1));
                check("rom_write", {24'd0, rom[i]}, {24'd0, pay_q[i]});
            end
            check("done_before_chk", {31'd0, done}, 32'd0);
            check("cpu_rst_before_chk", {31'd0, cpu_rst}, 32'd0);
            send_byte(chk, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        model_frame(n, chk, md, me, mb);
    endtask

    task automatic check_end(input bit md, input bit me, input logic [31:0] mb);
        check("done", {31'd0, done}, {31'd0, md});
        check("error", {31'd0, error}, {31'd0, me});
        check("cpu_rst", {31'd0, cpu_rst}, {31'd0, md});
        check("in_ready_end", {31'd0, in_ready}, 32'd0);
        check("bytes_loaded", bytes_loaded, mb);
        check_rom("rom_image");
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_bytes", bytes_loaded, 32'd0);
        check_rom("rst_rom");
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit md, me;
        logic [31:0] mb;
        logic [31:0] n;
        logic [7:0]  c;

        vt[0].n = 32'd8; vt[0].pay = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h24, 8'h09, 8'h00, 8'h02};
        vt[0].chk = 8'h1A; vt[0].exp_done = 1'b1; vt[0].exp_err = 1'b0; vt[0].exp_bytes = 32'd8;
        vt[1] = vt[0]; vt[1].chk = 8'h1B; vt[1].exp_done = 1'b0; vt[1].exp_err = 1'b1;
        vt[2].n = 32'd0; vt[2].pay = '{default: 8'h00}; vt[2].chk = 8'h00;
        vt[2].exp_done = 1'b1; vt[2].exp_err = 1'b0; vt[2].exp_bytes = 32'd0;
        vt[3] = vt[2]; vt[3].chk = 8'h5A; vt[3].exp_done = 1'b0; vt[3].exp_err = 1'b1;
        vt[4].n = 32'd4; vt[4].pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[4].chk = 8'h22; vt[4].exp_done = 1'b1; vt[4].exp_err = 1'b0; vt[4].exp_bytes = 32'd4;
        vt[5].n = 32'h0000_1001; vt[5].pay = '{default: 8'h00}; vt[5].chk = 8'h00;
        vt[5].exp_done = 1'b0; vt[5].exp_err = 1'b1; vt[5].exp_bytes = 32'd0;

        do_reset();
        check_reset_state();

        for (int v = 0; v < 6; v++) begin
            pay_q.delete();
            for (int i = 0; i < int'(vt[v].n) && i < 8; i++) pay_q.push_back(vt[v].pay[i]);
            run_frame(vt[v].n, vt[v].chk, 0, md, me, mb);
            check("tbl_done", {31'd0, done}, {31'd0, vt[v].exp_done});
            check("tbl_error", {31'd0, error}, {31'd0, vt[v].exp_err});
            check("tbl_cpu_rst", {31'd0, cpu_rst}, {31'd0, vt[v].exp_done});
            check("tbl_in_ready", {31'd0, in_ready}, 32'd0);
            check("tbl_bytes", bytes_loaded, vt[v].exp_bytes);
            check_rom("tbl_rom");
            if (v == 0) check("fetch_pc0", {rom[0], rom[1], rom[2], rom[3]}, 32'h3C080001);
            if (v == 4) begin
                check("fetch_pc0_reload", {rom[0], rom[1], rom[2], rom[3]}, 32'hDEADBEEF);
                check("rom_tail_kept", {rom[4], rom[5], rom[6], rom[7]}, 32'h24090002);
            end
            if (v == 5) begin
                in_valid = 1'b1; in_data = 8'h77;
                repeat (4) @(negedge clk);
                in_valid = 1'b0;
                check("err_no_accept_ready", {31'd0, in_ready}, 32'd0);
                check("err_no_accept_bytes", bytes_loaded, 32'd0);
                check_rom("err_no_accept_rom");
            end
        end

        // Reset in the middle of the payload, then a clean reload.
        pulse_start();
        for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        send_byte(8'h3C, 1); send_byte(8'h08, 0); send_byte(8'h00, 2);
        do_reset();
        check_reset_state();
        pay_q.delete();
        for (int i = 0; i < 8; i++) pay_q.push_back(vt[0].pay[i]);
        run_frame(32'd8, 8'h1A, 3, md, me, mb);
        check_end(md, me, mb);
        check("fetch_after_rst", {rom[0], rom[1], rom[2], rom[3]}, 32'h3C080001);

        // start during DATA must not restart the frame.
        pulse_start();
        for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0);
        pulse_start();
        send_byte(8'hBE, 0); send_byte(8'hEF, 0); send_byte(8'h22, 0);
        pay_q.delete();
        pay_q.push_back(8'hDE); pay_q.push_back(8'hAD); pay_q.push_back(8'hBE); pay_q.push_back(8'hEF);
        model_frame(32'd4, 8'h22, md, me, mb);
        check_end(md, me, mb);

        // start and a byte on the same edge in DONE: only start acts.
        start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        check("start_byte_ready", {31'd0, in_ready}, 32'd1);
        check("start_byte_bytes", bytes_loaded, 32'd0);
        check("start_byte_done", {31'd0, done}, 32'd0);
        check("start_byte_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        pay_q.delete();
        run_frame(32'd0, 8'h00, 0, md, me, mb);
        check_end(md, me, mb);

        // Length boundaries: exactly ROM_SIZE accepted, one more rejected.
        pay_q.delete();
        for (int i = 0; i < int'(RS); i++) pay_q.push_back(8'($urandom_range(0, 255)));
        c = 8'h00;
        foreach (pay_q[i]) c ^= pay_q[i];
        run_frame(RS, c, 0, md, me, mb);
        check("full_size_done", {31'd0, done}, 32'd1);
        check_end(md, me, mb);
        pay_q.delete();
        run_frame(RS + 1, 8'h00, 0, md, me, mb);
        check("over_size_err", {31'd0, error}, 32'd1);
        check_end(md, me, mb);

        // Randomized frames with idle gaps and occasional bad checks/lengths.
        for (int f = 0; f < 24; f++) begin
            pay_q.delete();
            if (f % 6 == 5) n = RS + 1 + $urandom_range(0, 100000);
            else if (f == 10) n = $urandom | 32'h8000_0000;
            else n = $urandom_range(0, 20);
            if (n <= RS) for (int i = 0; i < int'(n); i++) pay_q.push_back(8'($urandom_range(0, 255)));
            c = 8'h00;
            foreach (pay_q[i]) c ^= pay_q[i];
            if ($urandom_range(0, 3) == 0) c ^= 8'(1 << $urandom_range(0, 7));
            run_frame(n, c, 3, md, me, mb);
            check_end(md, me, mb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
